// File: rtl/config_pkg.sv
// Shared widths, word types and receive-state encoding for the operand
// assembly path between the read port and the execution unit.
package config_pkg;

  localparam int DATA_WIDTH   = 20;
  localparam int W_DATA_WIDTH = 2 * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0]   data_t;
  typedef logic [W_DATA_WIDTH-1:0] w_data_t;

  typedef enum logic [1:0] {
    RX_A    = 2'd0,
    RX_B    = 2'd1,
    RX_C_LO = 2'd2,
    RX_C_HI = 2'd3
  } rx_state_e;

endpackage

// File: rtl/receive_fsm.sv
// Assembles four read words (A, B, C low, C high) into one operand set and
// publishes it atomically with a single-cycle operation_valid_o strobe.
module receive_fsm
  import config_pkg::*;
#(
  parameter int DATA_WIDTH   = config_pkg::DATA_WIDTH,
  parameter int W_DATA_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    rd_data_valid_i,
  input  logic [DATA_WIDTH-1:0]   rd_data_i,
  output logic [DATA_WIDTH-1:0]   operand_a_o,
  output logic [DATA_WIDTH-1:0]   operand_b_o,
  output logic [W_DATA_WIDTH-1:0] operand_c_o,
  output logic                    operation_valid_o
);

  rx_state_e             state;
  logic [DATA_WIDTH-1:0] stage_a_p0;
  logic [DATA_WIDTH-1:0] stage_b_p0;
  logic [DATA_WIDTH-1:0] stage_c_lo_p0;

  // Staging stage: words land in per-state registers; the output stage only
  // updates on the C-high word so partial sets never become visible.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state             <= RX_A;
      stage_a_p0        <= '0;
      stage_b_p0        <= '0;
      stage_c_lo_p0     <= '0;
      operand_a_o       <= '0;
      operand_b_o       <= '0;
      operand_c_o       <= '0;
      operation_valid_o <= 1'b0;
    end else begin
      operation_valid_o <= 1'b0;
      if (rd_data_valid_i) begin
        case (state)
          RX_A: begin
            stage_a_p0 <= rd_data_i;
            state      <= RX_B;
          end
          RX_B: begin
            stage_b_p0 <= rd_data_i;
            state      <= RX_C_LO;
          end
          RX_C_LO: begin
            stage_c_lo_p0 <= rd_data_i;
            state         <= RX_C_HI;
          end
          RX_C_HI: begin
            operand_a_o       <= stage_a_p0;
            operand_b_o       <= stage_b_p0;
            operand_c_o       <= {rd_data_i, stage_c_lo_p0};
            operation_valid_o <= 1'b1;
            state             <= RX_A;
          end
          default: state <= RX_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receive_fsm.sv
// Directed bench for receive_fsm: reset, continuous, gapped, mid-set reset
// and reset-versus-C-high cases against hand-computed operand sets.
module tb_receive_fsm;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        rd_data_valid_i;
  logic [19:0] rd_data_i;
  logic [19:0] operand_a_o;
  logic [19:0] operand_b_o;
  logic [39:0] operand_c_o;
  logic        operation_valid_o;

  int total = 0;
  int bad   = 0;

  receive_fsm dut (
    .clk               (clk),
    .rst_i             (rst_i),
    .rd_data_valid_i   (rd_data_valid_i),
    .rd_data_i         (rd_data_i),
    .operand_a_o       (operand_a_o),
    .operand_b_o       (operand_b_o),
    .operand_c_o       (operand_c_o),
    .operation_valid_o (operation_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle; results of that edge are visible on return.
  task automatic step(input logic r, input logic v, input logic [19:0] d);
    rst_i           = r;
    rd_data_valid_i = v;
    rd_data_i       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_set(input string tag, input logic [19:0] a, input logic [19:0] b,
                           input logic [39:0] c);
    check({tag, "_a"}, 64'(operand_a_o), 64'(a));
    check({tag, "_b"}, 64'(operand_b_o), 64'(b));
    check({tag, "_c"}, 64'(operand_c_o), 64'(c));
  endtask

  logic [19:0] stream [12] = '{20'hABCDE, 20'hDEADF, 20'hCAFEA, 20'hFADED,
                               20'hCBBDE, 20'hFBAAE, 20'hDEADF, 20'hCAFEA,
                               20'hFADED, 20'hDEADF, 20'hCAFEA, 20'hFADED};
  logic [19:0] gset [4] = '{20'h11111, 20'h22222, 20'h33333, 20'h44444};
  int          strobes;
  logic        prev_strobe;

  initial begin
    rst_i = 1'b0; rd_data_valid_i = 1'b0; rd_data_i = '0;
    @(posedge clk); #1;

    // reset for two cycles
    step(1'b1, 1'b0, 20'h0);
    step(1'b1, 1'b0, 20'h0);
    check("rst_vld", 64'(operation_valid_o), 64'd0);
    check_set("rst", 20'h0, 20'h0, 40'h0);

    // continuous stream; first word after reset must become A
    strobes = 0;
    prev_strobe = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, stream[i]);
      check($sformatf("strm_vld%0d", i), 64'(operation_valid_o), 64'((i % 4) == 3));
      if (operation_valid_o) strobes++;
      if (prev_strobe && operation_valid_o) check("strm_consec", 64'd1, 64'd0);
      prev_strobe = operation_valid_o;
      if (i == 3)  check_set("set1", 20'hABCDE, 20'hDEADF, 40'hFADEDCAFEA);
      if (i >= 4 && i <= 6) check_set($sformatf("hold%0d", i), 20'hABCDE, 20'hDEADF, 40'hFADEDCAFEA);
      if (i == 7)  check_set("set2", 20'hCBBDE, 20'hFBAAE, 40'hCAFEADEADF);
      if (i == 11) check_set("set3", 20'hFADED, 20'hDEADF, 40'hFADEDCAFEA);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 20'hFFFFF);
      if (operation_valid_o) strobes++;
    end
    check("strm_count", 64'(strobes), 64'd3);
    check_set("after", 20'hFADED, 20'hDEADF, 40'hFADEDCAFEA);

    // gapped set, 1..3 idle cycles between words
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, gset[i]);
      if (i < 3) begin
        if (operation_valid_o) strobes++;
        for (int g = 0; g <= i; g++) begin
          step(1'b0, 1'b0, 20'hABABA);
          if (operation_valid_o) strobes++;
        end
      end
    end
    check("gap_vld", 64'(operation_valid_o), 64'd1);
    check("gap_early", 64'(strobes), 64'd0);
    check_set("gap", 20'h11111, 20'h22222, 40'h4444433333);
    step(1'b0, 1'b0, 20'h0);
    check("gap_vld_off", 64'(operation_valid_o), 64'd0);

    // mid-set reset discards A and B
    step(1'b0, 1'b1, 20'h0AAAA);
    step(1'b0, 1'b1, 20'h0BBBB);
    step(1'b1, 1'b0, 20'h0);
    check_set("midrst", 20'h0, 20'h0, 40'h0);
    strobes = 0;
    step(1'b0, 1'b1, 20'h55555); if (operation_valid_o) strobes++;
    step(1'b0, 1'b1, 20'h66666); if (operation_valid_o) strobes++;
    step(1'b0, 1'b1, 20'h77777); if (operation_valid_o) strobes++;
    step(1'b0, 1'b1, 20'h88888); if (operation_valid_o) strobes++;
    step(1'b0, 1'b0, 20'h0);     if (operation_valid_o) strobes++;
    check("midrst_count", 64'(strobes), 64'd1);
    check_set("midrst_new", 20'h55555, 20'h66666, 40'h8888877777);

    // reset coincident with the C-high word
    step(1'b0, 1'b1, 20'h12345);
    step(1'b0, 1'b1, 20'h23456);
    step(1'b0, 1'b1, 20'h34567);
    step(1'b1, 1'b1, 20'h45678);
    check("rstc_vld", 64'(operation_valid_o), 64'd0);
    check_set("rstc", 20'h0, 20'h0, 40'h0);
    step(1'b0, 1'b1, 20'h9ABCD);
    step(1'b0, 1'b1, 20'hBCDEF);
    step(1'b0, 1'b1, 20'h13579);
    check("rstc_nostrobe", 64'(operation_valid_o), 64'd0);
    step(1'b0, 1'b1, 20'h2468A);
    check("rstc_vld2", 64'(operation_valid_o), 64'd1);
    check_set("rstc_new", 20'h9ABCD, 20'hBCDEF, 40'h2468A13579);
    step(1'b0, 1'b0, 20'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/receive_fsm.md
# receive_fsm

Collects a stream of fixed-width words from the read-data path and assembles them into one operation: operand A, operand B and the double-width operand C. It sits between the read-side interface (memory/FIFO read port) and the operation execution unit. When a full operand set has been received, it presents the operands atomically with a one-cycle `operation_valid_o` strobe.

## Interface
Parameters:
- `DATA_WIDTH`, default 20: width of `data_t`; one received word, operand A and operand B.
- `W_DATA_WIDTH`, default 2*DATA_WIDTH (40): width of `w_data_t`; operand C.

Ports:
- `clk`  input  1  sole clock; all logic on the rising edge.
- `rst_i`  input  1  synchronous, active-high reset.
- `rd_data_valid_i`  input  1  `rd_data_i` holds a valid word this cycle.
- `rd_data_i`  input  DATA_WIDTH  incoming word.
- `operand_a_o`  output  DATA_WIDTH  assembled operand A.
- `operand_b_o`  output  DATA_WIDTH  assembled operand B.
- `operand_c_o`  output  W_DATA_WIDTH  assembled operand C.
- `operation_valid_o`  output  1  one-cycle strobe: operands are a new complete set.

## Operation
- Word order per operation: A, B, C low half, C high half (4 words).
- FSM states: `RX_A` → `RX_B` → `RX_C_LO` → `RX_C_HI` → `RX_A`.
- A state advances only on a cycle with `rd_data_valid_i`=1. The word is captured into the staging register for that state. With valid=0, the state and staging registers hold.
- The block is always ready: there is no backpressure and no ready output. Every valid word is consumed.
- In `RX_C_HI` with valid=1, the outputs load in one edge. `operand_a_o` and `operand_b_o` load from staging. `operand_c_o` loads {rd_data_i, staged C low}. `operation_valid_o` is set to 1 for that following cycle only.
- Outputs hold their last complete set until the next set completes. Partially received sets never appear on the outputs.
- Reset (any state, including mid-set): state → `RX_A`, and all staging registers, operand outputs and `operation_valid_o` → 0. Partial sets are discarded.
- Gaps (valid=0) may occur between any two words without loss or corruption.

## Timing
- All outputs are registered. Reset values: every operand 0 and `operation_valid_o`=0.
- Latency: `operation_valid_o` and the new operands appear on the cycle after the edge that accepts the C-high word.
- Back-to-back: with valid held high continuously, one operation completes every 4 cycles. The first word of the next set is accepted in the cycle the strobe is high. `operation_valid_o` is never high on two consecutive cycles.
- Synchronous reset wins over a simultaneous valid word; that word is dropped.

## Structure
- Shared package `config_pkg` holds the following:
  - `DATA_WIDTH` / `W_DATA_WIDTH` constants;
  - `data_t` (logic [DATA_WIDTH-1:0]) and `w_data_t` (logic [W_DATA_WIDTH-1:0]);
  - the state enum `rx_state_e`.
- The block is a single module with no sub-modules: one state register, three staging registers (A, B, C-low) and the output registers.

## Test plan
- Reset: assert `rst_i` for 2 cycles → all outputs 0, no strobe. Then a first word is captured as A.
- Continuous stream, valid=1 every cycle, words ABCDE, DEADF, CAFEA, FADED, CBBDE, FBAAE, DEADF, CAFEA, FADED, DEADF, CAFEA, FADED, then valid=0. Required response: three strobes, 4 cycles apart.
  - Set 1: A=ABCDE, B=DEADF, C=FADEDCAFEA.
  - Set 2: A=CBBDE, B=FBAAE, C=CAFEADEADF.
  - Set 3: A=FADED, B=DEADF, C=FADEDCAFEA.
  - After the stream, outputs hold set 3 and there are no further strobes.
- Gapped input: insert 1–3 idle cycles between each word of one set → same operands as the ungapped case, one strobe 1 cycle after the last word.
- Mid-set reset: send A and B, then assert reset, then send a full 4-word set → outputs reflect only the new set, with a single strobe.
- Output stability: during reception of set 2, the outputs must stay at set 1 values until the set-2 strobe cycle.
- Reset coincident with a valid C-high word → no strobe, outputs 0, state `RX_A`.
